// File: rtl/gpi_debounce.sv
// FPro slot core: W input pins through a 2-FF synchronizer, per-bit debounce filter and sticky W1C edge flags.
// Optional interrupt output and mask register at addr 5 when GPI_IRQ_EN is defined.
module gpi_debounce #(
  parameter int W = 8,
  parameter int CW = 16,
  parameter logic [CW-1:0] DB_INIT = CW'(1000)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [W-1:0]  din
`ifdef GPI_IRQ_EN
  ,
  output logic          irq
`endif
);

  logic [W-1:0]  s1;
  logic [W-1:0]  s2;
  logic [W-1:0]  stable;
  logic [W-1:0]  stable_nxt;
  logic [W-1:0]  rise_reg;
  logic [W-1:0]  fall_reg;
  logic [W-1:0]  rise_nxt;
  logic [W-1:0]  fall_nxt;
  logic [W-1:0]  rise_clr;
  logic [W-1:0]  fall_clr;
  logic [CW-1:0] db_lim;
  logic [CW-1:0] cnt     [W];
  logic [CW-1:0] cnt_nxt [W];
  logic          wr_en;
  logic          db_wr;

  // Reads have no side effects, so the read strobe only documents bus activity.
  logic unused_in;
  assign unused_in = ^{read, wr_data};

  assign wr_en    = cs && write;
  assign db_wr    = wr_en && (addr == 5'd4);
  assign rise_clr = (wr_en && (addr == 5'd1)) ? wr_data[W-1:0] : '0;
  assign fall_clr = (wr_en && (addr == 5'd2)) ? wr_data[W-1:0] : '0;

  // A period write restarts every filter so the new limit applies from a clean count.
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = cnt;
    for (int i = 0; i < W; i++) begin
      if (db_wr || (s2[i] == stable[i])) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == db_lim) begin
        stable_nxt[i] = s2[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  // Edge flags set in the same edge stable moves; a set beats a simultaneous clear.
  assign rise_nxt = (rise_reg & ~rise_clr) | (stable_nxt & ~stable);
  assign fall_nxt = (fall_reg & ~fall_clr) | (~stable_nxt & stable);

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1       <= '0;
      s2       <= '0;
      stable   <= '0;
      rise_reg <= '0;
      fall_reg <= '0;
      db_lim   <= DB_INIT;
      for (int i = 0; i < W; i++) cnt[i] <= '0;
    end else begin
      s1       <= din;
      s2       <= s1;
      stable   <= stable_nxt;
      rise_reg <= rise_nxt;
      fall_reg <= fall_nxt;
      if (db_wr) db_lim <= wr_data[CW-1:0];
      for (int i = 0; i < W; i++) cnt[i] <= cnt_nxt[i];
    end
  end

`ifdef GPI_IRQ_EN
  logic [W-1:0] irq_mask;

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && (addr == 5'd5)) irq_mask <= wr_data[W-1:0];
      irq <= |((rise_reg | fall_reg) & irq_mask);
    end
  end
`endif

  always_comb begin
    rd_data = '0;
    case (addr)
      5'd0: rd_data[W-1:0]  = stable;
      5'd1: rd_data[W-1:0]  = rise_reg;
      5'd2: rd_data[W-1:0]  = fall_reg;
      5'd3: rd_data[W-1:0]  = s2;
      5'd4: rd_data[CW-1:0] = db_lim;
`ifdef GPI_IRQ_EN
      5'd5: rd_data[W-1:0]  = irq_mask;
`endif
      default: rd_data = '0;
    endcase
  end

endmodule
